spi_rxc: RTL
============

// Module: spi_rxc
// PURPOSE
//  Receive-side SPI shift controller, the counterpart of the transmit shifter. One bit of shift_in is
//  sampled per sclk_rx edge while rx_en is high, and frames are assembled as 8, 16 or 32 bits.
//  Assembled words are presented to the register interface with an RXNE/overrun handshake.
//  In CRC mode, each block ends with one CRC frame; the block checks it against a serial CRC it computes itself.
// PARAMETERS
//  NUM_W  13  width of spi_rnum_max and of the data-frame counter
// PORTS
//  sclk_rx          in   1      receive clock; all state updates on its rising edge
//  spi_rx_rst       in   1      synchronous reset, active-high
//  rx_en            in   1      1 = sample shift_in this cycle; 0 = abort the partial frame
//  shift_in         in   1      serial data (mosi in slave mode, miso in master mode)
//  df               in   2      frame width: 00 = 8, 01 = 16, 1x = 32
//  lsbf             in   1      1 = first received bit is bit0; 0 = first bit is bit[W-1]
//  crc_en           in   1      enables CRC accumulation and the CRC-frame phase
//  crc_poly         in   32     CRC polynomial; only the low W bits are used
//  spi_rnum_max     in   NUM_W  data frames per CRC block (0 is treated as 1)
//  rd_ack           in   1      1-cycle pulse: rx_data has been read, clears rxne
//  ovr_clr          in   1      1-cycle pulse: clears ovr
//  rx_data          out  32     last data frame, right-justified, upper bits zero
//  rxne             out  1      rx_data holds an unread frame
//  ovr              out  1      sticky: a data frame arrived while rxne was 1
//  rx_frame_done    out  1      1-cycle pulse: any frame (data or CRC) completed
//  crc_done         out  1      1-cycle pulse: CRC frame completed
//  crc_err          out  1      sticky: received CRC differed from computed CRC
//  rx_crc_data_out  out  32     running computed CRC, zero-extended
// BEHAVIOUR
//  Reset: every output and internal register is 0. FSM state = S_DATA, bit_cnt = 0, frame count = 0.
//  Frame configuration: df and lsbf are latched when a sample is taken with bit_cnt = 0, and held until
//   the frame ends. A change to df or lsbf mid-frame has no effect until the next frame.
//  Bit counter: bit_cnt counts up from 0 on each sample. At W-1 the frame completes and bit_cnt wraps to 0.
//   When rx_en = 0, bit_cnt returns to 0 and the partial frame is discarded. CRC state and frame count hold.
//  Assembly: with lsbf = 0, the k-th sample lands in bit W-1-k. With lsbf = 1, it lands in bit k.
//   The completed word is available in the cycle after the last bit is sampled.
//  FSM:
//   S_DATA: each completed frame is a data frame and increments the frame count.
//    If crc_en = 1 and the count reaches max(spi_rnum_max, 1), the FSM moves to S_CRC and the count resets.
//    If crc_en = 0, the frame count stays 0 and the FSM never leaves S_DATA.
//   S_CRC: the next completed frame is the CRC frame. It is compared with the CRC value held before its
//    first bit. crc_done pulses, and crc_err is set on mismatch. rx_data and rxne are untouched.
//    The CRC register then reinitialises to 0 and the FSM returns to S_DATA.
//   If crc_en drops in S_CRC, the FSM returns to S_DATA and the CRC register reinitialises to 0.
//  RXNE handshake: a data-frame completion sets rxne and loads rx_data.
//   If rxne is already 1 and rd_ack is not asserted in the same cycle, rx_data is NOT overwritten and ovr is set.
//   If rd_ack and a completion occur in the same cycle, the new data loads, rxne stays 1 and there is no ovr.
//   ovr_clr takes priority over a same-cycle set.
//  CRC arithmetic: W-bit MSB-first LFSR with init 0, run on each data-frame sample in S_DATA while crc_en = 1.
//   fb = crc[W-1] ^ bit. crc <= {crc[W-2:0], 1'b0} ^ (crc_poly[W-1:0] & {W{fb}}).
//   W is taken from the current df. When crc_en = 0, the CRC register is held at 0.
//  crc_err is cleared only by reset or by crc_en = 0.
//  rx_frame_done and crc_done are asserted for exactly one cycle per completion.
//  Reset asserted mid-frame returns everything to reset values in the next cycle; no rxne is raised.
// TESTING
//  1. df=00, lsbf=0, rx_en=1, bits 1,1,0,0,0,0,0,0 -> rx_data=0x000000C0, with rxne and rx_frame_done
//     high in the cycle after bit 8.
//  2. Same bits with lsbf=1 -> rx_data=0x00000003. With df=01, lsbf=0, 16 bits of 0xBEEF -> rx_data=0x0000BEEF.
//  3. Two 8-bit frames 0x11 then 0x22, no rd_ack -> rx_data=0x11 and ovr=1. Then ovr_clr plus rd_ack
//     -> ovr=0 and rxne=0. rd_ack on the same cycle as a completion -> new data loads, ovr=0.
//  4. crc_en=1, df=00, crc_poly=0x07, spi_rnum_max=1. Data 0x01 -> rx_crc_data_out=0x07.
//     CRC frame 0x07 -> crc_done pulse, crc_err=0. Repeat the block with CRC frame 0x06 -> crc_err=1.
//  5. rx_en dropped after 5 bits, then 8 fresh bits of 0xA5 -> rx_data=0xA5, with no spurious frame_done.
//     Also: df switched mid-frame -> the frame completes at the original width.
//  6. spi_rx_rst pulsed after 3 bits of a frame -> all outputs 0. The next full 8-bit frame of 0x5A is
//     received intact.

Source files
------------

// File: rtl/spi_rxc.sv
// Receive-side SPI shift controller: assembles 8/16/32-bit frames from shift_in, presents them with an
// RXNE/overrun handshake, and in CRC mode checks the trailing CRC frame of each block against a serial LFSR.
module spi_rxc #(
  parameter int NUM_W = 13
) (
  input  logic             sclk_rx,
  input  logic             spi_rx_rst,
  input  logic             rx_en,
  input  logic             shift_in,
  input  logic [1:0]       df,
  input  logic             lsbf,
  input  logic             crc_en,
  input  logic [31:0]      crc_poly,
  input  logic [NUM_W-1:0] spi_rnum_max,
  input  logic             rd_ack,
  input  logic             ovr_clr,
  output logic [31:0]      rx_data,
  output logic             rxne,
  output logic             ovr,
  output logic             rx_frame_done,
  output logic             crc_done,
  output logic             crc_err,
  output logic [31:0]      rx_crc_data_out
);

  typedef enum logic {S_DATA = 1'b0, S_CRC = 1'b1} state_e;

  localparam logic [NUM_W-1:0] CNT_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       df_q, df_d;
  logic             lsbf_q, lsbf_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [31:0]      rx_data_q, rx_data_d;
  logic             rxne_q, rxne_d;
  logic             ovr_q, ovr_d;
  logic             frame_done_q, frame_done_d;
  logic             crc_done_q, crc_done_d;
  logic             crc_err_q, crc_err_d;

  logic [1:0]       df_eff;
  logic             lsbf_eff;
  logic [4:0]       width_m1;
  logic [4:0]       pos;
  logic [31:0]      wmask;
  logic [31:0]      word_new;
  logic [31:0]      crc_step;
  logic             fb;
  logic             last_bit;
  logic             data_done;
  logic             ovr_set;
  logic [NUM_W-1:0] limit;
  logic [NUM_W-1:0] cnt_inc;

  // Frame geometry comes from the live inputs on the first bit, from the latched copy afterwards.
  always_comb begin
    df_eff   = (bit_cnt_q == 5'd0) ? df : df_q;
    lsbf_eff = (bit_cnt_q == 5'd0) ? lsbf : lsbf_q;
    case (df_eff)
      2'b00:   begin width_m1 = 5'd7;  wmask = 32'h0000_00FF; end
      2'b01:   begin width_m1 = 5'd15; wmask = 32'h0000_FFFF; end
      default: begin width_m1 = 5'd31; wmask = 32'hFFFF_FFFF; end
    endcase
    pos      = lsbf_eff ? bit_cnt_q : (width_m1 - bit_cnt_q);
    last_bit = rx_en && (bit_cnt_q == width_m1);

    word_new      = (bit_cnt_q == 5'd0) ? 32'h0 : shreg_q;
    word_new[pos] = shift_in;

    fb       = crc_q[width_m1] ^ shift_in;
    crc_step = ((crc_q << 1) ^ (crc_poly & {32{fb}})) & wmask;

    limit    = (spi_rnum_max == '0) ? CNT_ONE : spi_rnum_max;
    cnt_inc  = cnt_q + CNT_ONE;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    df_d         = df_q;
    lsbf_d       = lsbf_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    rx_data_d    = rx_data_q;
    rxne_d       = rxne_q & ~rd_ack;
    ovr_set      = 1'b0;
    frame_done_d = 1'b0;
    crc_done_d   = 1'b0;
    crc_err_d    = crc_err_q;
    data_done    = 1'b0;

    if (!rx_en) begin
      bit_cnt_d = 5'd0;
    end else begin
      shreg_d = word_new;
      if (bit_cnt_q == 5'd0) begin
        df_d   = df;
        lsbf_d = lsbf;
      end
      bit_cnt_d = last_bit ? 5'd0 : (bit_cnt_q + 5'd1);
    end

    case (state_q)
      S_DATA: begin
        if (crc_en && rx_en) crc_d = crc_step;
        if (last_bit) begin
          frame_done_d = 1'b1;
          data_done    = 1'b1;
          if (crc_en) begin
            if (cnt_inc >= limit) begin
              state_d = S_CRC;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end
      S_CRC: begin
        if (!crc_en) begin
          state_d = S_DATA;
          crc_d   = 32'h0;
          if (last_bit) begin
            frame_done_d = 1'b1;
            data_done    = 1'b1;
          end
        end else if (last_bit) begin
          // The CRC register is frozen for the whole CRC frame, so crc_q is the pre-frame value.
          frame_done_d = 1'b1;
          crc_done_d   = 1'b1;
          if ((word_new & wmask) != crc_q) crc_err_d = 1'b1;
          crc_d   = 32'h0;
          state_d = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase

    if (data_done) begin
      if (!rxne_q || rd_ack) begin
        rx_data_d = word_new & wmask;
        rxne_d    = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end

    if (!crc_en) begin
      crc_d     = 32'h0;
      cnt_d     = '0;
      crc_err_d = 1'b0;
    end

    ovr_d = ovr_clr ? 1'b0 : (ovr_q | ovr_set);
  end

  always_ff @(posedge sclk_rx) begin
    if (spi_rx_rst) begin
      state_q      <= S_DATA;
      bit_cnt_q    <= 5'd0;
      df_q         <= 2'b00;
      lsbf_q       <= 1'b0;
      shreg_q      <= 32'h0;
      cnt_q        <= '0;
      crc_q        <= 32'h0;
      rx_data_q    <= 32'h0;
      rxne_q       <= 1'b0;
      ovr_q        <= 1'b0;
      frame_done_q <= 1'b0;
      crc_done_q   <= 1'b0;
      crc_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      df_q         <= df_d;
      lsbf_q       <= lsbf_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      rx_data_q    <= rx_data_d;
      rxne_q       <= rxne_d;
      ovr_q        <= ovr_d;
      frame_done_q <= frame_done_d;
      crc_done_q   <= crc_done_d;
      crc_err_q    <= crc_err_d;
    end
  end

  assign rx_data         = rx_data_q;
  assign rxne            = rxne_q;
  assign ovr             = ovr_q;
  assign rx_frame_done   = frame_done_q;
  assign crc_done        = crc_done_q;
  assign crc_err         = crc_err_q;
  assign rx_crc_data_out = crc_q;

endmodule
